// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

    // State encoding of the arbiter FSM
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ISSUE = ST_ISSUE,
        S_WAIT  = ST_WAIT
    } arb_state_t;

    // Default watchdog limit in s_tick units; one 8N1 frame at 16x is 160 ticks
    localparam int TO_TICKS_DEF = 255;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted req at or after last+1.
module rr_picker #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic                    valid,
    output logic [$clog2(NREQ)-1:0] winner
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] idx;

    // Scan from farthest to nearest so the nearest requester after last wins
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IW'((int'(last) + k) % NREQ);
            if (req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NREQ byte sources: round-robin arbitration,
// grant locking for multi-byte packets, and an s_tick watchdog on tx_done.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int TO_TICKS = TO_TICKS_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    s_tick,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         lock,
    input  logic [8*NREQ-1:0]       data_in,
    output logic [NREQ-1:0]         ack,
    output logic [NREQ-1:0]         done,
    output logic                    tx_start,
    output logic [7:0]              tx_din,
    input  logic                    tx_done,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    timeout_err
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TO_TICKS + 1);

    arb_state_t    state;
    logic [7:0]    hold;
    logic [IW-1:0] last;
    logic          lock_vld;
    logic [IW-1:0] lock_id;
    logic [CW-1:0] wd_cnt;

    logic          pick_vld;
    logic [IW-1:0] pick_id;
    logic          cap_vld;
    logic [IW-1:0] cap_id;
    logic [7:0]    cap_byte;
    logic          wd_hit;

    rr_picker #(.NREQ(NREQ)) u_pick (
        .req    (req),
        .last   (last),
        .valid  (pick_vld),
        .winner (pick_id)
    );

    // Who gets captured this cycle: lock owner, round-robin winner, or the
    // current owner continuing its packet straight out of WAIT
    always_comb begin
        cap_vld = 1'b0;
        cap_id  = pick_id;
        if (state == S_IDLE) begin
            if (lock_vld && lock[lock_id]) begin
                cap_vld = req[lock_id];
                cap_id  = lock_id;
            end else begin
                cap_vld = pick_vld;
            end
        end else if (state == S_WAIT) begin
            cap_vld = tx_done && lock[grant_id] && req[grant_id];
            cap_id  = grant_id;
        end
    end

    // Byte mux for the captured requester
    always_comb begin
        cap_byte = '0;
        for (int i = 0; i < NREQ; i++)
            if (cap_id == IW'(i)) cap_byte = data_in[8*i +: 8];
    end

    // Watchdog expires on the tick that would bring the count to TO_TICKS
    assign wd_hit = (state == S_WAIT) && s_tick && (wd_cnt >= CW'(TO_TICKS - 1));

    // done must coincide with tx_done, so it is decoded rather than registered
    assign done   = (state == S_WAIT && tx_done) ? (NREQ'(1) << grant_id) : '0;
    assign tx_din = hold;

    // Arbiter FSM with hold register, lock owner and watchdog
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            hold        <= '0;
            grant_id    <= '0;
            last        <= IW'(NREQ - 1);
            lock_vld    <= 1'b0;
            lock_id     <= '0;
            wd_cnt      <= '0;
            tx_start    <= 1'b0;
            ack         <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            tx_start    <= 1'b0;
            ack         <= '0;
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Owner released the lock: fall back to round-robin
                    if (lock_vld && !lock[lock_id]) lock_vld <= 1'b0;
                    if (cap_vld) begin
                        hold     <= cap_byte;
                        grant_id <= cap_id;
                        last     <= cap_id;
                        tx_start <= 1'b1;
                        ack      <= NREQ'(1) << cap_id;
                        busy     <= 1'b1;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wd_cnt <= '0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (tx_done) begin
                        lock_vld <= lock[grant_id];
                        lock_id  <= grant_id;
                        if (cap_vld) begin
                            hold     <= cap_byte;
                            tx_start <= 1'b1;
                            ack      <= NREQ'(1) << grant_id;
                            state    <= S_ISSUE;
                        end else begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end else if (wd_hit) begin
                        timeout_err <= 1'b1;
                        lock_vld    <= 1'b0;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else if (s_tick && wd_cnt != CW'(TO_TICKS)) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a tick-counting uart_tx model.
module tb_uart_tx_arbiter;

    localparam int NREQ = 3;
    localparam int TO   = 255;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              s_tick = 1'b0;
    logic              tx_done = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ-1:0]   lock = '0;
    logic [8*NREQ-1:0] data_in = '0;
    logic [NREQ-1:0]   ack, done;
    logic              tx_start, busy, timeout_err;
    logic [7:0]        tx_din;
    logic [1:0]        grant_id;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // uart_tx model: raises tx_done on the m_frame-th tick after tx_start (0 = never)
    int m_frame = 160;
    bit m_act = 0;
    int m_ticks = 0;
    int tick_to_cyc = 0;

    logic [7:0] log_din[$];
    int         log_gid[$];
    int start_cyc, done_cyc, to_cyc;
    int n_start, n_done, n_to;
    int n_ack[NREQ];
    int n_dn[NREQ];
    int last_gid = 0;
    int req_cyc;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NREQ(NREQ), .TO_TICKS(TO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .s_tick      (s_tick),
        .req         (req),
        .lock        (lock),
        .data_in     (data_in),
        .ack         (ack),
        .done        (done),
        .tx_start    (tx_start),
        .tx_din      (tx_din),
        .tx_done     (tx_done),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive tick/tx_done after the edge, then observe outputs
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        s_tick  = (cyc % 2 == 0);
        tx_done = 1'b0;
        if (m_act && s_tick) begin
            m_ticks++;
            if (m_ticks == TO) tick_to_cyc = cyc;
            if (m_frame != 0 && m_ticks == m_frame) begin
                tx_done = 1'b1;
                m_act   = 0;
            end
        end
        #1;
        if (tx_start) begin
            log_din.push_back(tx_din);
            log_gid.push_back(int'(grant_id));
            start_cyc = cyc;
            n_start++;
            m_act    = 1;
            m_ticks  = 0;
            last_gid = int'(grant_id);
            chk("ack_with_start", 32'(ack), 32'(1) << grant_id);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (ack[i])  n_ack[i]++;
            if (done[i]) n_dn[i]++;
        end
        if (done != '0) begin
            done_cyc = cyc;
            n_done++;
            chk("done_onehot", 32'(done), 32'(1) << last_gid);
            chk("done_with_tx_done", 32'(tx_done), 32'd1);
        end
        if (timeout_err) begin
            to_cyc = cyc;
            n_to++;
            m_act = 0;
        end
    endtask

    task automatic clear_logs();
        log_din.delete();
        log_gid.delete();
        n_start = 0;
        n_done  = 0;
        n_to    = 0;
        for (int i = 0; i < NREQ; i++) begin
            n_ack[i] = 0;
            n_dn[i]  = 0;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        m_act   = 0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    // Wait for a done or timeout pulse, bounded
    task automatic wait_evt(input string tag, input int max);
        int base;
        int k;
        base = n_done + n_to;
        k = 0;
        while (n_done + n_to == base && k < max) begin
            step();
            k++;
        end
        if (n_done + n_to == base) chk({tag, "_bound"}, 32'd0, 32'd1);
    endtask

    task automatic wait_start(input string tag, input int max);
        int base;
        int k;
        base = n_start;
        k = 0;
        while (n_start == base && k < max) begin
            step();
            k++;
        end
        if (n_start == base) chk({tag, "_bound"}, 32'd0, 32'd1);
    endtask

    initial begin
        clear_logs();

        // Reset state
        step();
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_din", 32'(tx_din), 32'h00);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        step();
        reset_n = 1'b1;

        // Single byte from requester 0, 160-tick frame
        clear_logs();
        m_frame = 160;
        data_in[7:0] = 8'hA5;
        req = 3'b001;
        req_cyc = cyc;
        step();
        chk("s1_start_latency", 32'(start_cyc), 32'(req_cyc + 1));
        chk("s1_tx_din", 32'(tx_din), 32'hA5);
        chk("s1_busy_issue", 32'(busy), 32'd1);
        req = 3'b000;
        wait_evt("s1_done", 400);
        chk("s1_done0_count", 32'(n_dn[0]), 32'd1);
        chk("s1_ack0_count", 32'(n_ack[0]), 32'd1);
        chk("s1_din_held", 32'(tx_din), 32'hA5);
        chk("s1_busy_at_done", 32'(busy), 32'd1);
        step();
        chk("s1_busy_idle", 32'(busy), 32'd0);
        chk("s1_start_count", 32'(n_start), 32'd1);

        // Round-robin over three held requests
        do_reset();
        clear_logs();
        m_frame = 20;
        data_in = {8'h33, 8'h22, 8'h11};
        req = 3'b111;
        for (int t = 0; t < 4; t++) wait_evt("s2_done", 120);
        req = 3'b000;
        step();
        step();
        chk("s2_start_count", 32'(log_din.size()), 32'd4);
        chk("s2_din0", 32'(log_din[0]), 32'h11);
        chk("s2_din1", 32'(log_din[1]), 32'h22);
        chk("s2_din2", 32'(log_din[2]), 32'h33);
        chk("s2_din3", 32'(log_din[3]), 32'h11);
        chk("s2_gid1", 32'(log_gid[1]), 32'd1);
        chk("s2_gid2", 32'(log_gid[2]), 32'd2);
        chk("s2_gid3", 32'(log_gid[3]), 32'd0);

        // Locked three-byte packet from requester 1, requester 0 waiting
        clear_logs();
        data_in[7:0]  = 8'h55;
        data_in[15:8] = 8'h08;
        lock = 3'b010;
        req  = 3'b011;
        wait_start("s3_start0", 5);
        chk("s3_gid_first", 32'(grant_id), 32'd1);
        chk("s3_din_first", 32'(tx_din), 32'h08);
        data_in[15:8] = 8'h12;
        wait_evt("s3_done0", 120);
        step();
        chk("s3_b2b_1", 32'(start_cyc), 32'(done_cyc + 1));
        chk("s3_din_second", 32'(tx_din), 32'h12);
        data_in[15:8] = 8'hF0;
        wait_evt("s3_done1", 120);
        step();
        chk("s3_b2b_2", 32'(start_cyc), 32'(done_cyc + 1));
        chk("s3_din_third", 32'(tx_din), 32'hF0);
        req = 3'b001;
        wait_evt("s3_done2", 120);
        for (int t = 0; t < 10; t++) step();
        chk("s3_starved", 32'(n_start), 32'd3);
        lock = 3'b000;
        step();
        chk("s3_unlock_start", 32'(n_start), 32'd4);
        chk("s3_unlock_gid", 32'(grant_id), 32'd0);
        chk("s3_unlock_din", 32'(tx_din), 32'h55);
        req = 3'b000;
        wait_evt("s3_done3", 120);
        chk("s3_done1_count", 32'(n_dn[1]), 32'd3);
        chk("s3_done0_count", 32'(n_dn[0]), 32'd1);

        // Watchdog: tx_done never arrives
        clear_logs();
        m_frame = 0;
        data_in[23:16] = 8'h3C;
        req = 3'b100;
        wait_start("s4_start", 5);
        req = 3'b000;
        wait_evt("s4_timeout", 600);
        chk("s4_timeout_count", 32'(n_to), 32'd1);
        chk("s4_no_done", 32'(n_done), 32'd0);
        chk("s4_timeout_cycle", 32'(to_cyc), 32'(tick_to_cyc + 1));
        chk("s4_busy_idle", 32'(busy), 32'd0);
        step();
        chk("s4_timeout_pulse", 32'(timeout_err), 32'd0);
        m_frame = 20;
        data_in[23:16] = 8'h9A;
        req = 3'b100;
        wait_start("s4_restart", 5);
        chk("s4_gid", 32'(grant_id), 32'd2);
        chk("s4_din", 32'(tx_din), 32'h9A);
        req = 3'b000;
        wait_evt("s4_done", 120);
        chk("s4_done2_count", 32'(n_dn[2]), 32'd1);

        // tx_done on the same tick the watchdog would expire
        clear_logs();
        m_frame = TO;
        data_in[7:0] = 8'h5A;
        req = 3'b001;
        wait_start("s5_start", 5);
        req = 3'b000;
        wait_evt("s5_done", 600);
        chk("s5_done_count", 32'(n_done), 32'd1);
        chk("s5_done_cycle", 32'(done_cyc), 32'(tick_to_cyc));
        step();
        step();
        chk("s5_no_timeout", 32'(n_to), 32'd0);

        // Reset in WAIT during a locked packet
        clear_logs();
        m_frame = 20;
        data_in[7:0]  = 8'h66;
        data_in[15:8] = 8'h44;
        lock = 3'b010;
        req  = 3'b010;
        wait_start("s6_start", 5);
        data_in[15:8] = 8'h45;
        wait_evt("s6_done", 120);
        step();
        chk("s6_second_din", 32'(tx_din), 32'h45);
        for (int t = 0; t < 5; t++) step();
        reset_n = 1'b0;
        req = 3'b011;
        m_act = 0;
        #1;
        chk("s6_rst_busy", 32'(busy), 32'd0);
        chk("s6_rst_grant", 32'(grant_id), 32'd0);
        chk("s6_rst_tx_din", 32'(tx_din), 32'h00);
        chk("s6_rst_done", 32'(done), 32'd0);
        chk("s6_rst_start", 32'(tx_start), 32'd0);
        step();
        step();
        reset_n = 1'b1;
        step();
        chk("s6_after_rst_start", 32'(tx_start), 32'd1);
        chk("s6_after_rst_gid", 32'(grant_id), 32'd0);
        chk("s6_after_rst_din", 32'(tx_din), 32'h66);
        req  = 3'b000;
        lock = 3'b000;
        wait_evt("s6_done_after", 120);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
